// File: rtl/csr_backing_ram.sv
`default_nettype none
// ============================================================================
// Module   : csr_backing_ram
// Brief    : Single-port byte-enabled backing RAM for the CSR-to-RAM bridge,
//            with 1/2-cycle read latency and an optional post-reset clear.
// Revision : 1.0 - initial release
// ============================================================================
module csr_backing_ram #(
    parameter int WORD_BIT_WIDTH      = 32,
    parameter int WORD_ADDR_BIT_WIDTH = 6,
    parameter bit OUTPUT_REG_IS_USED  = 1'b0,
    parameter bit INIT_CLEAR_EN       = 1'b1
) (
    input  logic                             i_clk,
    input  logic                             i_sync_rst,
    input  logic                             i_we,
    input  logic [WORD_ADDR_BIT_WIDTH-1:0]   i_word_addr,
    input  logic [WORD_BIT_WIDTH/8-1:0]      i_wr_byte_en,
    input  logic [WORD_BIT_WIDTH-1:0]        i_wr_data,
    output logic [WORD_BIT_WIDTH-1:0]        o_rd_data,
    output logic                             o_init_busy
);

    localparam int c_DEPTH = 2 ** WORD_ADDR_BIT_WIDTH;
    localparam int c_BYTES = WORD_BIT_WIDTH / 8;

    localparam logic [0:0] c_ST_READY = 1'b0;
    localparam logic [0:0] c_ST_CLEAR = 1'b1;
    localparam logic [0:0] c_ST_RESET = INIT_CLEAR_EN ? c_ST_CLEAR : c_ST_READY;

    localparam logic [WORD_ADDR_BIT_WIDTH-1:0] c_LAST_ADDR = '1;

    logic [0:0]                     r_state;
    logic [WORD_ADDR_BIT_WIDTH-1:0] r_clr_addr;
    logic [WORD_BIT_WIDTH-1:0]      r_mem [c_DEPTH];
    logic [WORD_BIT_WIDTH-1:0]      r_rd;

    logic                           w_clearing;
    logic                           w_wr_en;
    logic [WORD_ADDR_BIT_WIDTH-1:0] w_wr_addr;
    logic [c_BYTES-1:0]             w_wr_be;
    logic [WORD_BIT_WIDTH-1:0]      w_wr_data;

    assign w_clearing  = (r_state == c_ST_CLEAR);
    assign o_init_busy = w_clearing;

    // Clear sequencer: one word per cycle, READY after the last address.
    always_ff @(posedge i_clk) begin
        if (i_sync_rst) begin
            r_state    <= c_ST_RESET;
            r_clr_addr <= '0;
        end else if (w_clearing) begin
            r_clr_addr <= r_clr_addr + 1'b1;
            if (r_clr_addr == c_LAST_ADDR) begin
                r_state <= c_ST_READY;
            end
        end
    end

    // The clear owns the write port; external writes are dropped meanwhile.
    always_comb begin
        w_wr_en   = 1'b0;
        w_wr_addr = i_word_addr;
        w_wr_be   = i_wr_byte_en;
        w_wr_data = i_wr_data;
        if (!i_sync_rst) begin
            if (w_clearing) begin
                w_wr_en   = 1'b1;
                w_wr_addr = r_clr_addr;
                w_wr_be   = '1;
                w_wr_data = '0;
            end else begin
                w_wr_en   = i_we;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_wr_en) begin
            for (int b = 0; b < c_BYTES; b++) begin
                if (w_wr_be[b]) begin
                    r_mem[w_wr_addr][b*8 +: 8] <= w_wr_data[b*8 +: 8];
                end
            end
        end
    end

    // Read-first: the nonblocking write lands after this read samples.
    always_ff @(posedge i_clk) begin
        if (i_sync_rst) begin
            r_rd <= '0;
        end else if (w_clearing) begin
            r_rd <= '0;
        end else begin
            r_rd <= r_mem[i_word_addr];
        end
    end

    generate
        if (OUTPUT_REG_IS_USED) begin : g_out_reg
            logic [WORD_BIT_WIDTH-1:0] r_rd_q;
            always_ff @(posedge i_clk) begin
                if (i_sync_rst) begin
                    r_rd_q <= '0;
                end else begin
                    r_rd_q <= r_rd;
                end
            end
            assign o_rd_data = r_rd_q;
        end else begin : g_no_out_reg
            assign o_rd_data = r_rd;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_csr_backing_ram.sv
`default_nettype none
// ============================================================================
// Module   : tb_csr_backing_ram
// Brief    : Directed plus random bench for csr_backing_ram, latency 1 and 2.
// Revision : 1.0 - initial release
// ============================================================================
module tb_csr_backing_ram;

    localparam int c_DEPTH = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        we = 1'b0;
    logic [5:0]  addr = '0;
    logic [3:0]  be = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rd0, rd1;
    logic        busy0, busy1;

    int checks = 0;
    int errors = 0;

    // Reference: plain word array, remaining-clear count, two-deep output history.
    logic [31:0] m_mem [c_DEPTH];
    int          clr_left = c_DEPTH;
    logic [31:0] p1 = '0;
    logic [31:0] p2 = '0;

    always #5 clk = ~clk;

    csr_backing_ram #(
        .WORD_BIT_WIDTH(32), .WORD_ADDR_BIT_WIDTH(6),
        .OUTPUT_REG_IS_USED(1'b0), .INIT_CLEAR_EN(1'b1)
    ) u_dut0 (
        .i_clk(clk), .i_sync_rst(rst), .i_we(we), .i_word_addr(addr),
        .i_wr_byte_en(be), .i_wr_data(wdata), .o_rd_data(rd0), .o_init_busy(busy0)
    );

    csr_backing_ram #(
        .WORD_BIT_WIDTH(32), .WORD_ADDR_BIT_WIDTH(6),
        .OUTPUT_REG_IS_USED(1'b1), .INIT_CLEAR_EN(1'b1)
    ) u_dut1 (
        .i_clk(clk), .i_sync_rst(rst), .i_we(we), .i_word_addr(addr),
        .i_wr_byte_en(be), .i_wr_data(wdata), .o_rd_data(rd1), .o_init_busy(busy1)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic step(input logic rst_v, input logic we_v, input logic [5:0] a,
                        input logic [3:0] be_v, input logic [31:0] d);
        logic [31:0] mask;
        logic [31:0] rdv;
        @(negedge clk);
        rst = rst_v; we = we_v; addr = a; be = be_v; wdata = d;
        @(posedge clk);
        if (rst_v) begin
            clr_left = c_DEPTH;
            p1 = '0;
            p2 = '0;
        end else begin
            rdv = (clr_left > 0) ? 32'h0 : m_mem[a];
            p2 = p1;
            p1 = rdv;
            if (clr_left > 0) begin
                m_mem[c_DEPTH - clr_left] = 32'h0;
                clr_left--;
            end else if (we_v) begin
                mask = {{8{be_v[3]}}, {8{be_v[2]}}, {8{be_v[1]}}, {8{be_v[0]}}};
                m_mem[a] = (m_mem[a] & ~mask) | (d & mask);
            end
        end
        #1;
        chk("busy_lat1", {31'b0, busy0}, {31'b0, clr_left > 0});
        chk("busy_lat2", {31'b0, busy1}, {31'b0, clr_left > 0});
        chk("rd_lat1", rd0, p1);
        chk("rd_lat2", rd1, p2);
    endtask

    task automatic idle(input logic [5:0] a);
        step(1'b0, 1'b0, a, 4'h0, 32'h0);
    endtask

    int cnt;

    initial begin
        // Reset state
        repeat (3) step(1'b1, 1'b0, 6'd0, 4'h0, 32'h0);
        chk("reset_rd0", rd0, 32'h0);
        chk("reset_rd1", rd1, 32'h0);
        chk("reset_busy", {31'b0, busy0}, 32'h1);

        // Busy for exactly DEPTH cycles after release
        cnt = 0;
        for (int i = 0; i < 100 && busy0; i++) begin
            cnt++;
            idle(6'd0);
        end
        chk("busy_len", cnt, 32'd64);

        // Sweep read after clear
        for (int a = 0; a < c_DEPTH; a++) begin
            idle(6'(a));
            chk("sweep_zero", rd0, 32'h0);
        end
        idle(6'd0);

        // Full word write then read
        step(1'b0, 1'b1, 6'd5, 4'hF, 32'hDEADBEEF);
        idle(6'd5);
        chk("wr_full_lat1", rd0, 32'hDEADBEEF);
        idle(6'd5);
        chk("wr_full_lat2", rd1, 32'hDEADBEEF);

        // Partial byte enable and zero byte enable
        step(1'b0, 1'b1, 6'd5, 4'h5, 32'h11223344);
        idle(6'd5);
        chk("wr_be5", rd0, 32'hDE22BE44);
        step(1'b0, 1'b1, 6'd5, 4'h0, 32'h99999999);
        idle(6'd5);
        chk("wr_be0", rd0, 32'hDE22BE44);

        // Read-during-write returns old data
        step(1'b0, 1'b1, 6'd9, 4'hF, 32'hA5A5A5A5);
        step(1'b0, 1'b1, 6'd9, 4'hF, 32'h0F0F0F0F);
        chk("rdw_old_lat1", rd0, 32'hA5A5A5A5);
        idle(6'd9);
        chk("rdw_new_lat1", rd0, 32'h0F0F0F0F);
        chk("rdw_old_lat2", rd1, 32'hA5A5A5A5);
        idle(6'd9);
        chk("rdw_new_lat2", rd1, 32'h0F0F0F0F);

        // Reset mid-clear restarts; writes during clear are dropped
        step(1'b0, 1'b1, 6'd2, 4'hF, 32'h12345678);
        step(1'b1, 1'b0, 6'd0, 4'h0, 32'h0);
        repeat (20) idle(6'd0);
        repeat (3) step(1'b1, 1'b0, 6'd0, 4'h0, 32'h0);
        cnt = 0;
        for (int i = 0; i < 100 && busy0; i++) begin
            cnt++;
            step(1'b0, (i == 10), 6'd2, 4'hF, 32'hFFFFFFFF);
        end
        chk("busy_len_restart", cnt, 32'd64);
        idle(6'd2);
        chk("clr_drop_lat1", rd0, 32'h0);
        idle(6'd5);
        chk("clr_drop_lat2", rd1, 32'h0);
        chk("clr_wiped_5", rd0, 32'h0);

        // Top and bottom addresses are distinct
        step(1'b0, 1'b1, 6'd63, 4'hF, 32'h1);
        step(1'b0, 1'b1, 6'd0, 4'hF, 32'h2);
        idle(6'd63);
        chk("addr63_lat1", rd0, 32'h1);
        idle(6'd0);
        chk("addr0_lat1", rd0, 32'h2);
        chk("addr63_lat2", rd1, 32'h1);
        idle(6'd0);
        chk("addr0_lat2", rd1, 32'h2);

        // Random traffic with occasional resets
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 149) == 0), 1'($urandom_range(0, 1)),
                 6'($urandom_range(0, 63)), 4'($urandom_range(0, 15)), $urandom);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
